// File: rtl/multicycle_alu.sv
// Handshake-driven ALU: single-cycle logic/arithmetic/branch ops plus iterative
// unsigned shift-add multiply and restoring divide, one bit per clock.
module multicycle_alu #(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1,
  parameter bit DIV_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             cout,
  output logic             bcond,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_TCP, OP_SHL, OP_SHR,
    OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ, OP_MULU, OP_DIVU, OP_LHI, OP_PASS
  } op_e;

  op_e op_in;
  assign op_in = op_e'(op);

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;        // multiplicand or divisor
  logic [WIDTH-1:0] work_hi_q, work_hi_d;  // partial product high / remainder
  logic [WIDTH-1:0] work_lo_q, work_lo_d;  // multiplier bits / dividend->quotient
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic             cout_q, cout_d;
  logic             bcond_q, bcond_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;

  // One shift-add step: add multiplicand when the current multiplier bit is set,
  // then shift the {hi, lo} pair right by one.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_n, mul_lo_n;
  assign mul_sum  = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_hi_n = mul_sum[WIDTH:1];
  assign mul_lo_n = {mul_sum[0], work_lo_q[WIDTH-1:1]};

  // One restoring-division step: shift in the next dividend bit, keep the
  // difference only when it does not borrow.
  logic [WIDTH:0]   div_shift, div_diff;
  logic             div_ok;
  logic [WIDTH-1:0] div_hi_n, div_lo_n;
  assign div_shift = {work_hi_q, work_lo_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_ok    = ~div_diff[WIDTH];
  assign div_hi_n  = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_lo_n  = {work_lo_q[WIDTH-2:0], div_ok};

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves a latch behind.
    state_d     = state_q;
    count_d     = count_q;
    opnd_d      = opnd_q;
    work_hi_d   = work_hi_q;
    work_lo_d   = work_lo_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    cout_d      = cout_q;
    bcond_d     = bcond_q;
    dbz_d       = dbz_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (op_in == OP_MULU && MUL_EN) begin
            state_d   = MUL;
            count_d   = '0;
            opnd_d    = a;
            work_hi_d = '0;
            work_lo_d = b;
          end else if (op_in == OP_DIVU && DIV_EN && b != '0) begin
            state_d   = DIV;
            count_d   = '0;
            opnd_d    = b;
            work_hi_d = '0;
            work_lo_d = a;
          end else begin
            done_d      = 1'b1;
            result_d    = a;
            result_hi_d = '0;
            cout_d      = 1'b0;
            bcond_d     = 1'b0;
            dbz_d       = 1'b0;
            case (op_in)
              OP_ADD:  {cout_d, result_d} = {1'b0, a} + {1'b0, b};
              OP_SUB:  {cout_d, result_d} = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
              OP_AND:  result_d = a & b;
              OP_OR:   result_d = a | b;
              OP_NOT:  result_d = ~a;
              OP_TCP:  result_d = ~a + WIDTH'(1);
              OP_SHL:  result_d = {a[WIDTH-2:0], 1'b0};
              OP_SHR:  result_d = {a[WIDTH-1], a[WIDTH-1:1]};
              OP_BNE:  bcond_d  = (a != b);
              OP_BEQ:  bcond_d  = (a == b);
              OP_BGZ:  bcond_d  = ~a[WIDTH-1] && (a != '0);
              OP_BLZ:  bcond_d  = a[WIDTH-1];
              OP_DIVU: begin
                // Only reached here with a zero divisor (or divide disabled).
                if (DIV_EN) begin
                  result_d    = '1;
                  result_hi_d = a;
                  dbz_d       = 1'b1;
                end
              end
              OP_LHI:  result_d = b << (WIDTH / 2);
              default: result_d = a;
            endcase
          end
        end
      end

      MUL: begin
        work_hi_d = mul_hi_n;
        work_lo_d = mul_lo_n;
        count_d   = count_q + CW'(1);
        if (count_q == LAST_ITER) begin
          state_d     = IDLE;
          done_d      = 1'b1;
          result_d    = mul_lo_n;
          result_hi_d = mul_hi_n;
          cout_d      = 1'b0;
          bcond_d     = 1'b0;
          dbz_d       = 1'b0;
        end
      end

      DIV: begin
        work_hi_d = div_hi_n;
        work_lo_d = div_lo_n;
        count_d   = count_q + CW'(1);
        if (count_q == LAST_ITER) begin
          state_d     = IDLE;
          done_d      = 1'b1;
          result_d    = div_lo_n;
          result_hi_d = div_hi_n;
          cout_d      = 1'b0;
          bcond_d     = 1'b0;
          dbz_d       = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments here so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      opnd_q      <= '0;
      work_hi_q   <= '0;
      work_lo_q   <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      cout_q      <= 1'b0;
      bcond_q     <= 1'b0;
      dbz_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      opnd_q      <= opnd_d;
      work_hi_q   <= work_hi_d;
      work_lo_q   <= work_lo_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      cout_q      <= cout_d;
      bcond_q     <= bcond_d;
      dbz_q       <= dbz_d;
      done_q      <= done_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign result      = result_q;
  assign result_hi   = result_hi_q;
  assign cout        = cout_q;
  assign bcond       = bcond_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu: a 16-bit full instance and an 8-bit
// instance with multiply disabled, both checked against an arithmetic model.
module tb_multicycle_alu;

  typedef struct {
    logic [15:0] res;
    logic [15:0] hi;
    logic        cout;
    logic        bcond;
    logic        dbz;
    int          lat;
    int          done_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rst_seen = 1'b1;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_fail = 0;

  logic        start16 = 1'b0, start8 = 1'b0;
  logic [3:0]  op16 = '0, op8 = '0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy16, done16, cout16, bcond16, dbz16;
  logic [15:0] res16, hi16;
  logic        busy8, done8, cout8, bcond8, dbz8;
  logic [7:0]  res8, hi8;

  exp_t        q16[$];
  exp_t        q8[$];
  logic [34:0] last16 = '0;
  logic [18:0] last8 = '0;

  multicycle_alu #(.WIDTH(16), .MUL_EN(1'b1), .DIV_EN(1'b1)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .op(op16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .result(res16), .result_hi(hi16),
    .cout(cout16), .bcond(bcond16), .div_by_zero(dbz16)
  );

  multicycle_alu #(.WIDTH(8), .MUL_EN(1'b0), .DIV_EN(1'b1)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(res8), .result_hi(hi8),
    .cout(cout8), .bcond(bcond8), .div_by_zero(dbz8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= reset;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference behaviour in plain integer arithmetic; lat = edges after acceptance.
  function automatic exp_t model(input int w, input bit mul_en, input bit div_en,
                                 input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
    longint unsigned m, msb, ua, ub, t;
    exp_t e;
    m   = (64'd1 << w) - 64'd1;
    msb = 64'd1 << (w - 1);
    ua  = 64'(x) & m;
    ub  = 64'(y) & m;
    e.res = 16'(ua); e.hi = '0; e.cout = 1'b0; e.bcond = 1'b0; e.dbz = 1'b0;
    e.lat = 0; e.done_cyc = 0;
    case (o)
      4'd0:  begin t = ua + ub; e.res = 16'(t & m); e.cout = t[w]; end
      4'd1:  begin t = ua + (~ub & m) + 64'd1; e.res = 16'(t & m); e.cout = t[w]; end
      4'd2:  e.res = 16'(ua & ub);
      4'd3:  e.res = 16'(ua | ub);
      4'd4:  e.res = 16'(~ua & m);
      4'd5:  e.res = 16'((~ua + 64'd1) & m);
      4'd6:  e.res = 16'((ua << 1) & m);
      4'd7:  e.res = 16'((ua >> 1) | (ua & msb));
      4'd8:  e.bcond = (ua != ub);
      4'd9:  e.bcond = (ua == ub);
      4'd10: e.bcond = (ua != 0) && ((ua & msb) == 0);
      4'd11: e.bcond = ((ua & msb) != 0);
      4'd12: if (mul_en) begin
               t = ua * ub; e.res = 16'(t & m); e.hi = 16'(t >> w); e.lat = w;
             end
      4'd13: if (div_en) begin
               if (ub == 0) begin e.res = 16'(m); e.hi = 16'(ua); e.dbz = 1'b1; end
               else begin e.res = 16'(ua / ub); e.hi = 16'(ua % ub); e.lat = w; end
             end
      4'd14: e.res = 16'((ub << (w / 2)) & m);
      default: ;
    endcase
    return e;
  endfunction

  // Issue one op at a negedge, queue its expectation, then ride out the busy
  // window (optionally firing starts that must be ignored). Returns on the
  // negedge where done is due, so the next issue is back-to-back.
  task automatic drive(input bit w8, input logic [3:0] o, input logic [15:0] x,
                       input logic [15:0] y, input int junk_pct);
    exp_t e;
    if (w8) e = model(8, 1'b0, 1'b1, o, {8'h00, x[7:0]}, {8'h00, y[7:0]});
    else    e = model(16, 1'b1, 1'b1, o, x, y);
    e.done_cyc = cyc + 1 + e.lat;
    if (w8) begin
      q8.push_back(e); start8 = 1'b1; op8 = o; a8 = x[7:0]; b8 = y[7:0];
    end else begin
      q16.push_back(e); start16 = 1'b1; op16 = o; a16 = x; b16 = y;
    end
    @(negedge clk);
    for (int i = 0; i < e.lat; i++) begin
      check(w8 ? "w8_busy" : "w16_busy", w8 ? busy8 : busy16, 1);
      if (w8) begin
        start8 = ($urandom_range(99) < junk_pct);
        op8 = 4'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
      end else begin
        start16 = ($urandom_range(99) < junk_pct);
        op16 = 4'($urandom); a16 = 16'($urandom); b16 = 16'($urandom);
      end
      @(negedge clk);
    end
    start16 = 1'b0;
    start8  = 1'b0;
  endtask

  function automatic logic [15:0] rnd16();
    case ($urandom_range(7))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  always @(negedge clk) begin : mon16
    exp_t e;
    if (rst_seen) last16 = '0;
    if (done16) begin
      if (q16.size() == 0) begin
        n_vec++; n_fail++;
        $display("FAIL w16_unexpected_done: done=1 with nothing outstanding (cycle %0d)", cyc);
      end else begin
        e = q16.pop_front();
        check("w16_latency", 64'(cyc), 64'(e.done_cyc));
        check("w16_busy_at_done", busy16, 0);
        check("w16_result", res16, e.res);
        check("w16_result_hi", hi16, e.hi);
        check("w16_cout_bcond_dbz", {cout16, bcond16, dbz16}, {e.cout, e.bcond, e.dbz});
        last16 = {e.res, e.hi, e.cout, e.bcond, e.dbz};
      end
    end else begin
      if (q16.size() != 0 && cyc > q16[0].done_cyc) begin
        n_vec++; n_fail++;
        $display("FAIL w16_missing_done: no done by cycle %0d (due %0d)", cyc, q16[0].done_cyc);
        void'(q16.pop_front());
      end
      check("w16_hold", {res16, hi16, cout16, bcond16, dbz16}, last16);
    end
  end

  always @(negedge clk) begin : mon8
    exp_t e;
    if (rst_seen) last8 = '0;
    if (done8) begin
      if (q8.size() == 0) begin
        n_vec++; n_fail++;
        $display("FAIL w8_unexpected_done: done=1 with nothing outstanding (cycle %0d)", cyc);
      end else begin
        e = q8.pop_front();
        check("w8_latency", 64'(cyc), 64'(e.done_cyc));
        check("w8_busy_at_done", busy8, 0);
        check("w8_result", res8, e.res[7:0]);
        check("w8_result_hi", hi8, e.hi[7:0]);
        check("w8_cout_bcond_dbz", {cout8, bcond8, dbz8}, {e.cout, e.bcond, e.dbz});
        last8 = {e.res[7:0], e.hi[7:0], e.cout, e.bcond, e.dbz};
      end
    end else begin
      if (q8.size() != 0 && cyc > q8[0].done_cyc) begin
        n_vec++; n_fail++;
        $display("FAIL w8_missing_done: no done by cycle %0d (due %0d)", cyc, q8[0].done_cyc);
        void'(q8.pop_front());
      end
      check("w8_hold", {res8, hi8, cout8, bcond8, dbz8}, last8);
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    check("reset_state16", {busy16, done16, res16, hi16, cout16, bcond16, dbz16}, '0);
    check("reset_state8", {busy8, done8, res8, hi8, cout8, bcond8, dbz8}, '0);
    reset = 1'b0;
    @(negedge clk);

    // Directed cases from the 16-bit plan.
    drive(1'b0, 4'd0,  16'h7FFF, 16'h0001, 0);
    drive(1'b0, 4'd1,  16'd3,    16'd5,    0);
    drive(1'b0, 4'd1,  16'd5,    16'd3,    0);
    drive(1'b0, 4'd12, 16'h1234, 16'h0100, 100);
    drive(1'b0, 4'd13, 16'd100,  16'd7,    30);
    drive(1'b0, 4'd13, 16'h00AB, 16'h0000, 0);
    drive(1'b0, 4'd10, 16'h0000, 16'h0000, 0);
    drive(1'b0, 4'd10, 16'h0001, 16'h0000, 0);
    drive(1'b0, 4'd11, 16'h8000, 16'h0000, 0);
    drive(1'b0, 4'd9,  16'd5,    16'd5,    0);
    drive(1'b0, 4'd8,  16'd5,    16'd5,    0);

    // Reset during the eighth multiply cycle: the op must vanish without done.
    start16 = 1'b1; op16 = 4'd12; a16 = 16'h0007; b16 = 16'h0009;
    @(negedge clk);
    start16 = 1'b0;
    repeat (7) @(negedge clk);
    check("mid_mul_busy", busy16, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_outputs", {busy16, done16, res16, hi16, cout16, bcond16, dbz16}, '0);
    repeat (20) @(negedge clk);
    drive(1'b0, 4'd12, 16'd3, 16'd4, 0);

    // Randomised traffic, including ignored starts during iterative ops.
    for (int i = 0; i < 250; i++)
      drive(1'b0, 4'($urandom), rnd16(), rnd16(), 30);

    // 8-bit instance with multiply disabled.
    drive(1'b1, 4'd12, 16'h00FF, 16'h0002, 0);
    drive(1'b1, 4'd14, 16'h0000, 16'h000A, 0);
    drive(1'b1, 4'd13, 16'd200,  16'd9,    50);
    for (int i = 0; i < 120; i++)
      drive(1'b1, 4'($urandom), rnd16(), rnd16(), 30);

    repeat (4) @(negedge clk);
    check("w16_drain", 64'(q16.size()), 0);
    check("w8_drain", 64'(q8.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
